// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: result selects, load funct3 codes and FSM states.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    RESULT_SEL_ALU       = 2'd0,
    RESULT_SEL_LOAD      = 2'd1,
    RESULT_SEL_PC_PLUS_4 = 2'd2,
    RESULT_SEL_IMM       = 2'd3
  } result_sel_t;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    WB_STATE_IDLE      = 1'b0,
    WB_STATE_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Combinational load alignment: picks the byte/half addressed by offset and extends it.
module writeback_stage_load_aligner
  import writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword loads ignore offset[0]; misalignment is the memory stage's concern.
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNCT3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: waits for load responses, selects the result and issues a
// registered one-cycle register-file write plus retire pulse per instruction.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Flush,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rd_Addr,
  input  logic                      i_Rd_Write_Enable,
  input  logic [1:0]                i_Result_Select,
  input  logic [XLEN-1:0]           i_Alu_Result,
  input  logic [XLEN-1:0]           i_Pc_Plus_4,
  input  logic [XLEN-1:0]           i_Immediate,
  input  logic [2:0]                i_Load_Funct3,
  input  logic                      i_Mem_Read_Valid,
  input  logic [XLEN-1:0]           i_Mem_Read_Data,
  output logic                      o_Reg_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Reg_Write_Addr,
  output logic [XLEN-1:0]           o_Reg_Write_Data,
  output logic                      o_Retire
);

  wb_state_t                 state, state_next;
  result_sel_t               sel;
  logic [REG_ADDR_WIDTH-1:0] cap_rd;
  logic                      cap_we;
  logic [2:0]                cap_funct3;
  logic [1:0]                cap_offset;
  logic                      load_accept;
  logic                      fire;
  logic                      fire_we;
  logic                      commit;
  logic [REG_ADDR_WIDTH-1:0] fire_addr;
  logic [XLEN-1:0]           fire_data;
  logic [XLEN-1:0]           load_data;

  assign sel     = result_sel_t'(i_Result_Select);
  assign o_Ready = (state == WB_STATE_IDLE);

  writeback_stage_load_aligner #(
    .XLEN(XLEN)
  ) u_load_aligner (
    .word   (i_Mem_Read_Data),
    .offset (cap_offset),
    .funct3 (cap_funct3),
    .result (load_data)
  );

  always_comb begin
    state_next  = state;
    load_accept = 1'b0;
    fire        = 1'b0;
    fire_we     = 1'b0;
    fire_addr   = i_Rd_Addr;
    fire_data   = i_Alu_Result;
    case (state)
      WB_STATE_IDLE: begin
        if (i_Valid) begin
          if (sel == RESULT_SEL_LOAD) begin
            load_accept = 1'b1;
            state_next  = WB_STATE_WAIT_LOAD;
          end else begin
            fire    = 1'b1;
            fire_we = i_Rd_Write_Enable;
            case (sel)
              RESULT_SEL_PC_PLUS_4: fire_data = i_Pc_Plus_4;
              RESULT_SEL_IMM:       fire_data = i_Immediate;
              default:              fire_data = i_Alu_Result;
            endcase
          end
        end
      end
      WB_STATE_WAIT_LOAD: begin
        if (i_Mem_Read_Valid) begin
          fire       = 1'b1;
          fire_we    = cap_we;
          fire_addr  = cap_rd;
          fire_data  = load_data;
          state_next = WB_STATE_IDLE;
        end
      end
      default: state_next = WB_STATE_IDLE;
    endcase
    // Flush overrides everything decided above, including an accept while Ready is high.
    if (i_Flush) begin
      state_next  = WB_STATE_IDLE;
      load_accept = 1'b0;
      fire        = 1'b0;
    end
  end

  assign commit = fire & fire_we & (fire_addr != '0);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= WB_STATE_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cap_rd     <= '0;
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_offset <= '0;
    end else if (load_accept) begin
      cap_rd     <= i_Rd_Addr;
      cap_we     <= i_Rd_Write_Enable;
      cap_funct3 <= i_Load_Funct3;
      cap_offset <= i_Alu_Result[1:0];
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Reg_Write_Enable <= 1'b0;
      o_Reg_Write_Addr   <= '0;
      o_Reg_Write_Data   <= '0;
      o_Retire           <= 1'b0;
    end else begin
      o_Retire           <= fire;
      o_Reg_Write_Enable <= commit;
      if (commit) begin
        o_Reg_Write_Addr <= fire_addr;
        o_Reg_Write_Data <= fire_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a cycle-level behavioural model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] alu = '0;
  logic [31:0] pc4 = '0;
  logic [31:0] imm = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        retire;

  int tests = 0;
  int fails = 0;

  // model state
  bit          m_wait = 0;
  logic [4:0]  m_rd = '0;
  logic        m_we = 1'b0;
  logic [2:0]  m_f3 = '0;
  logic [1:0]  m_off = '0;
  logic        e_we = 1'b0;
  logic        e_ret = 1'b0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;

  always #5 clk = ~clk;

  writeback_stage #(
    .XLEN(32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .i_Clock            (clk),
    .i_Reset            (rst),
    .i_Flush            (flush),
    .i_Valid            (valid),
    .o_Ready            (ready),
    .i_Rd_Addr          (rd_addr),
    .i_Rd_Write_Enable  (rd_we),
    .i_Result_Select    (sel),
    .i_Alu_Result       (alu),
    .i_Pc_Plus_4        (pc4),
    .i_Immediate        (imm),
    .i_Load_Funct3      (funct3),
    .i_Mem_Read_Valid   (mem_valid),
    .i_Mem_Read_Data    (mem_data),
    .o_Reg_Write_Enable (wr_en),
    .o_Reg_Write_Addr   (wr_addr),
    .o_Reg_Write_Data   (wr_data),
    .o_Retire           (retire)
  );

  function automatic logic [31:0] ref_align(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    int unsigned b;
    int unsigned h;
    b = (w >> (int'(off) * 8)) & 32'hFF;
    h = (w >> ((int'(off) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".we"},     32'(wr_en),   32'(e_we));
    chk({tag, ".addr"},   32'(wr_addr), 32'(e_addr));
    chk({tag, ".data"},   wr_data,      e_data);
    chk({tag, ".retire"}, 32'(retire),  32'(e_ret));
  endtask

  // One clock: check Ready, predict the edge from current inputs, advance, check outputs.
  task automatic cycle(string tag);
    logic        f;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    chk({tag, ".ready"}, 32'(ready), 32'(!m_wait));
    f = 1'b0; we = 1'b0; rd = '0; d = '0;
    if (flush) begin
      m_wait = 0;
    end else if (!m_wait) begin
      if (valid) begin
        if (sel == 2'd1) begin
          m_wait = 1; m_rd = rd_addr; m_we = rd_we; m_f3 = funct3; m_off = alu[1:0];
        end else begin
          f = 1'b1; rd = rd_addr; we = rd_we;
          d = (sel == 2'd0) ? alu : (sel == 2'd2) ? pc4 : imm;
        end
      end
    end else if (mem_valid) begin
      f = 1'b1; rd = m_rd; we = m_we; d = ref_align(mem_data, m_off, m_f3);
      m_wait = 0;
    end
    e_ret = f;
    e_we  = f && we && (rd != 0);
    if (e_we) begin
      e_addr = rd;
      e_data = d;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; mem_valid = 1'b0; sel = 2'd0; rd_we = 1'b0;
  endtask

  task automatic alu_op(logic [4:0] rd, logic [1:0] s, logic [31:0] value);
    valid = 1'b1; sel = s; rd_addr = rd; rd_we = 1'b1;
    alu = value; pc4 = value; imm = value;
  endtask

  task automatic do_load(string tag, logic [4:0] rd, logic [1:0] off, logic [2:0] f3,
                         logic [31:0] word, logic [31:0] exp_const);
    valid = 1'b1; sel = 2'd1; rd_addr = rd; rd_we = 1'b1; funct3 = f3;
    alu = {30'h1234_5678 >> 2, off};
    cycle({tag, ".acc"});
    idle_inputs();
    valid = 1'b1;
    cycle({tag, ".wait0"});
    cycle({tag, ".wait1"});
    idle_inputs();
    mem_valid = 1'b1; mem_data = word;
    cycle({tag, ".resp"});
    chk({tag, ".const"}, wr_data, exp_const);
    idle_inputs();
    cycle({tag, ".after"});
  endtask

  initial begin
    #12;
    check_outputs("reset");
    chk("reset.ready", 32'(ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: simple ALU write
    alu_op(5'd5, 2'd0, 32'h0000_1234);
    cycle("t1");
    chk("t1.const", wr_data, 32'h0000_1234);
    idle_inputs();
    cycle("t1.idle");

    // 2: loads
    do_load("t2.lb",  5'd9,  2'd3, 3'b000, 32'h80FF_7F01, 32'hFFFF_FF80);
    do_load("t2.lbu", 5'd9,  2'd3, 3'b100, 32'h80FF_7F01, 32'h0000_0080);
    do_load("t2.lhu", 5'd11, 2'd2, 3'b101, 32'h80FF_7F01, 32'h0000_80FF);
    do_load("t2.lh",  5'd12, 2'd3, 3'b001, 32'h80FF_7F01, 32'hFFFF_80FF);

    // 3: rd=0 retires without a write; JAL link value
    alu_op(5'd0, 2'd0, 32'hCAFE_0000);
    cycle("t3.rd0");
    chk("t3.rd0.retire_const", 32'(retire), 32'd1);
    chk("t3.rd0.we_const", 32'(wr_en), 32'd0);
    alu_op(5'd1, 2'd2, 32'h0000_0104);
    cycle("t3.jal");
    chk("t3.jal.const", wr_data, 32'h0000_0104);

    // 4: back-to-back ALU transfers
    for (int i = 0; i < 3; i++) begin
      alu_op(5'(20 + i), 2'(i == 1 ? 3 : 0), 32'h1000 + 32'(i));
      cycle("t4.b2b");
    end
    idle_inputs();
    cycle("t4.idle");

    // 5: flush together with a load response, then a stale response
    valid = 1'b1; sel = 2'd1; rd_addr = 5'd3; rd_we = 1'b1; funct3 = 3'b010; alu = 32'h0;
    cycle("t5.acc");
    idle_inputs();
    cycle("t5.wait");
    flush = 1'b1; mem_valid = 1'b1; mem_data = 32'h5555_AAAA;
    cycle("t5.flush");
    idle_inputs();
    mem_valid = 1'b1;
    cycle("t5.stale");
    idle_inputs();
    cycle("t5.idle");

    // 6: asynchronous reset while a load is pending
    alu_op(5'd7, 2'd0, 32'hDEAD_BEEF);
    cycle("t6.pre");
    valid = 1'b1; sel = 2'd1; rd_addr = 5'd8; rd_we = 1'b1; funct3 = 3'b000;
    cycle("t6.acc");
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    m_wait = 0; e_we = 1'b0; e_ret = 1'b0; e_addr = '0; e_data = '0;
    check_outputs("t6.async");
    chk("t6.async.ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_valid = 1'b1; mem_data = 32'hFFFF_FFFF;
    cycle("t6.stale");
    idle_inputs();
    alu_op(5'd10, 2'd0, 32'h0000_00AB);
    cycle("t6.alu");
    idle_inputs();
    cycle("t6.idle");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      valid     = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      rd_addr   = 5'($urandom_range(0, 31));
      rd_we     = 1'($urandom_range(0, 3) != 0);
      alu       = $urandom;
      pc4       = $urandom;
      imm       = $urandom;
      funct3    = 3'($urandom_range(0, 7));
      mem_valid = 1'($urandom_range(0, 2) == 0);
      mem_data  = $urandom;
      flush     = 1'($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
